fetch_queue: RTL
================

# fetch_queue

Instruction prefetch buffer that sits between the program-counter/instruction-memory fetch stage and the decode stage of the pipelined MIPS core. It accepts one {pc, instr} pair per cycle from fetch, stores up to DEPTH entries in order, and presents the oldest entry to decode with a valid/ready handshake. Its `o_ready` drives the PC register's enable, so a full queue freezes fetch. A redirect (branch/jump resolved in decode) flushes all buffered entries.

## Interface
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `AW`, 32: PC / instruction width.

- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `i_valid` in 1: fetch presents a valid entry.
- `i_pc` in AW: PC of the fetched instruction.
- `i_instr` in AW: instruction word from IM.
- `o_ready` out 1: queue can accept; wired to PC `i_en`.
- `i_flush` in 1: discard all entries (redirect).
- `o_valid` out 1: head entry valid.
- `o_pc` out AW: head PC.
- `o_instr` out AW: head instruction.
- `i_ready` in 1: decode accepts head (not stalled).
- `o_count` out $clog2(DEPTH)+1: current occupancy.

## Operation
- Push = `i_valid && o_ready`; pop = `o_valid && i_ready`.
- `o_ready = (count != DEPTH)`. It has no combinational dependence on `i_ready`, so a full queue refuses a push even when a pop occurs in the same cycle.
- Storage is a circular buffer with head/tail pointers of width $clog2(DEPTH). Pointers wrap modulo DEPTH.
- Occupancy updates:
  - push only: +1.
  - pop only: −1.
  - push and pop in the same cycle: unchanged, both pointers advance.
- Order is strict FIFO. No entry is reordered or duplicated.
- Flush:
  - `i_flush=1` sets count=0 and head=tail=0 at the next edge.
  - Flush has priority over push and pop in the same cycle. The push in a flush cycle is discarded, and the pop is still reported to decode but the entry is not counted.
- When `o_valid=0`, `o_pc` and `o_instr` are forced to 0.
- The queue is not a state machine. It has two implicit conditions: empty (count=0) and full (count=DEPTH).

## Timing
- Reset: count=0, head=tail=0, `o_valid=0`, `o_pc=0`, `o_instr=0`, `o_ready=1`. Storage contents are don't-care.
- Reset applied mid-operation behaves exactly as a flush plus pointer clear, and takes priority over flush.
- Latency without bypass: an entry pushed at edge N appears at the head (`o_valid=1`) in cycle N+1.
- Throughput is one push and one pop per cycle.
- `o_valid`, `o_pc` and `o_instr` depend only on registered state, unless bypass is enabled.
- Empty plus pop attempt: no effect, because pop requires `o_valid`.
- Full plus push attempt: not accepted; fetch holds its PC because `o_ready=0`.

## Configuration
- `FQ_BYPASS_EN` defined:
  - When count=0 and `i_flush=0`, the input passes combinationally to the output: `o_valid=i_valid`, `o_pc=i_pc`, `o_instr=i_instr`.
  - If `i_ready=1`, the entry is consumed that cycle and not stored.
  - If `i_ready=0`, it is stored normally.
  - Zero-cycle latency when empty.
- Undefined: no bypass. The output is always the registered head, with a minimum latency of 1 cycle.

## Structure
- Shared package/header `cpu_defs`: `PC_RESET` = 32'h00003000, `INSTR_NOP` = 32'h00000000, and the AW width constant. The queue uses `INSTR_NOP` for its idle output.
- One sub-module, `fq_mem`:
  - DEPTH×(2·AW) register array.
  - Synchronous write port (`we`, `waddr`, `wdata`).
  - Asynchronous read port (`raddr`, `rdata`).
  - No reset.
- Top level holds the pointers, the counter, and the push/pop/flush/bypass logic.

## Test plan
- Reset, then push 4 entries (pc 0x3000..0x300c, instr 0x1..0x4) with `i_ready=0`:
  - `o_count`=4 and `o_ready=0`.
  - A fifth push with pc 0x3010 is refused.
  - Raise `i_ready`: outputs 0x3000..0x300c appear in order, one per cycle.
- Continuous push and pop with `i_ready=1` for 20 cycles: `o_count` stays constant and pointers wrap past DEPTH. Output pc sequence equals input sequence delayed by 1 cycle (0 cycles with `FQ_BYPASS_EN` when the queue is empty).
- Fill 3 entries, then assert `i_flush` together with `i_valid` (pc 0x3040):
  - Next cycle `o_count`=0, `o_valid=0`, `o_pc=0`.
  - A push of pc 0x3080 afterward is the next output.
- Full queue with simultaneous `i_valid=1` and `i_ready=1`: the pop occurs, the push is refused, and `o_count` goes 4→3.
- Assert `reset` with 2 entries buffered and `i_valid=1`: next cycle count=0, `o_valid=0`, `o_ready=1`.
- Bypass build: empty queue, `i_valid=1`, `i_ready=1`, pc 0x3000: `o_valid=1` and `o_pc=0x3000` in the same cycle, and `o_count` stays 0.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared core definitions: datapath width, reset PC and the idle instruction word.
package cpu_defs;

   localparam int          AW        = 32;
   localparam logic [31:0] PC_RESET  = 32'h0000_3000;
   localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

endpackage

// File: rtl/fq_mem.sv
// Entry storage for the fetch queue: synchronous write, asynchronous read, no reset.
module fq_mem #(
   parameter int DEPTH = 4,
   parameter int DW    = 64
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DW-1:0]            wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DW-1:0]            rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// In-order {pc, instr} prefetch buffer between fetch and decode; flush on redirect.
// Optional same-cycle bypass when empty is enabled by defining FQ_BYPASS_EN.
module fetch_queue
   import cpu_defs::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = cpu_defs::AW
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_valid,
   input  logic [AW-1:0]              i_pc,
   input  logic [AW-1:0]              i_instr,
   output logic                       o_ready,
   input  logic                       i_flush,
   output logic                       o_valid,
   output logic [AW-1:0]              o_pc,
   output logic [AW-1:0]              o_instr,
   input  logic                       i_ready,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [CW-1:0]   count;
   logic            empty;
   logic            full;
   logic            bypass;
   logic            push;
   logic            pop;
   logic            wr_en;
   logic            rd_adv;
   logic [2*AW-1:0] rd_data;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign o_ready = !full;
   assign o_count = count;

`ifdef FQ_BYPASS_EN
   assign bypass = empty && !i_flush;
`else
   assign bypass = 1'b0;
`endif

   always_comb begin
      o_valid = !empty;
      o_pc    = rd_data[2*AW-1:AW];
      o_instr = rd_data[AW-1:0];
      if (bypass) begin
         o_valid = i_valid;
         o_pc    = i_pc;
         o_instr = i_instr;
      end
      if (!o_valid) begin
         o_pc    = '0;
         o_instr = AW'(INSTR_NOP);
      end
   end

   assign push = i_valid && o_ready;
   assign pop  = o_valid && i_ready;

   // A bypassed entry that decode takes this cycle never touches storage.
   assign wr_en  = push && !(bypass && i_ready) && !i_flush && !reset;
   assign rd_adv = pop && !bypass;

   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (wr_en) begin
            tail <= tail + PW'(1);
         end
         if (rd_adv) begin
            head <= head + PW'(1);
         end
         case ({wr_en, rd_adv})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   fq_mem #(
      .DEPTH (DEPTH),
      .DW    (2*AW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (tail),
      .wdata ({i_pc, i_instr}),
      .raddr (head),
      .rdata (rd_data)
   );

endmodule
